// File: rtl/img_pkg.sv
// Shared definitions for the image byte writer: serializer states,
// the BMP byte order inside a pixel pair, and the row pad length helper.
package img_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BYTES = 2'd1,
        S_PAD   = 2'd2
    } ser_state_t;

    // Position of each byte within the six-byte BMP sequence of one pair
    localparam logic [2:0] BYTE_B0 = 3'd0;
    localparam logic [2:0] BYTE_G0 = 3'd1;
    localparam logic [2:0] BYTE_R0 = 3'd2;
    localparam logic [2:0] BYTE_B1 = 3'd3;
    localparam logic [2:0] BYTE_G1 = 3'd4;
    localparam logic [2:0] BYTE_R1 = 3'd5;

    // Zero bytes needed after a row of 'width' RGB pixels to reach a 4-byte boundary
    function automatic int row_pad_bytes(input int width);
        return (4 - ((width * 3) % 4)) % 4;
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO holding pixel pairs. Flags are registered so the
// writer sees a clean full/empty at the start of every cycle. A push while
// full is ignored even when a pop happens in the same cycle.
module pair_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Occupancy after this cycle's accepted push/pop
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage array, written only by an accepted push
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered flags; flush empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/image_byte_writer.sv
// Sink for the two-pixel-per-clock RGB stream: buffers pixel pairs and
// serialises them as BMP-ordered bytes (B,G,R per pixel) over valid/ready.
// Tracks row/column position, pulses frame_done after the last byte of a
// frame and keeps a sticky overflow flag for dropped pairs.
// Optional: define IMAGE_WRITER_ROW_PAD_EN to append zero bytes after every
// row so each row is a multiple of 4 bytes.
module image_byte_writer
    import img_pkg::*;
#(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 V_sync,
    input  logic                                 H_sync,
    input  logic [DATA_WIDTH-1:0]                red_0,
    input  logic [DATA_WIDTH-1:0]                green_0,
    input  logic [DATA_WIDTH-1:0]                blue_0,
    input  logic [DATA_WIDTH-1:0]                red_1,
    input  logic [DATA_WIDTH-1:0]                green_1,
    input  logic [DATA_WIDTH-1:0]                blue_1,
    output logic [DATA_WIDTH-1:0]                byte_data,
    output logic                                 byte_valid,
    input  logic                                 byte_ready,
    output logic                                 frame_done,
    output logic                                 overflow,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    pixel_count
);

    localparam int PAIR_W = 6 * DATA_WIDTH;
    localparam int PC_W   = $clog2(WIDTH * HEIGHT + 1);
    localparam int COL_W  = $clog2(WIDTH + 1);
    localparam int ROW_W  = $clog2(HEIGHT + 1);
`ifdef IMAGE_WRITER_ROW_PAD_EN
    localparam int PAD_LEN = row_pad_bytes(WIDTH);
`endif

    ser_state_t        state;
    logic [PAIR_W-1:0] hold;
    logic [2:0]        byte_idx;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_next;
    logic [ROW_W-1:0]  row;
    logic              v_sync_prev;
    logic              frame_start;
    logic              accept;
    logic              pair_done;
    logic              row_end;
    logic              last_row;
    logic              pop;
    logic              go_next;
    logic              finish;
    logic [PAIR_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
`ifdef IMAGE_WRITER_ROW_PAD_EN
    logic [1:0]        pad_cnt;
    logic              pad_last;
    logic              enter_pad;
`endif

    // Select one byte of a stored pair {r0,g0,b0,r1,g1,b1} in BMP order
    function automatic logic [DATA_WIDTH-1:0] pick_byte(input logic [PAIR_W-1:0] pair,
                                                        input logic [2:0] idx);
        logic [DATA_WIDTH-1:0] b;
        case (idx)
            BYTE_B0: b = pair[3*DATA_WIDTH +: DATA_WIDTH];
            BYTE_G0: b = pair[4*DATA_WIDTH +: DATA_WIDTH];
            BYTE_R0: b = pair[5*DATA_WIDTH +: DATA_WIDTH];
            BYTE_B1: b = pair[0*DATA_WIDTH +: DATA_WIDTH];
            BYTE_G1: b = pair[1*DATA_WIDTH +: DATA_WIDTH];
            BYTE_R1: b = pair[2*DATA_WIDTH +: DATA_WIDTH];
            default: b = '0;
        endcase
        return b;
    endfunction

    assign frame_start = V_sync && !v_sync_prev;
    assign accept      = byte_valid && byte_ready;
    assign pair_done   = (state == S_BYTES) && accept && (byte_idx == BYTE_R1);
    assign col_next    = col + COL_W'(2);
    assign row_end     = (col_next == COL_W'(WIDTH));
    assign last_row    = (row == ROW_W'(HEIGHT - 1));
`ifdef IMAGE_WRITER_ROW_PAD_EN
    assign pad_last    = (pad_cnt == 2'(PAD_LEN - 1));
`endif

    pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (H_sync && !frame_start),
        .pop   (pop),
        .din   ({red_0, green_0, blue_0, red_1, green_1, blue_1}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Remember V_sync so a new frame starts only on its rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sync_prev <= 1'b0;
        end else begin
            v_sync_prev <= V_sync;
        end
    end

    // Decide where the serializer goes when the current pair or pad finishes
    always_comb begin
        pop     = 1'b0;
        go_next = 1'b0;
        finish  = 1'b0;
`ifdef IMAGE_WRITER_ROW_PAD_EN
        enter_pad = 1'b0;
`endif
        case (state)
            S_IDLE: pop = !fifo_empty;
            S_BYTES: begin
                if (pair_done) begin
`ifdef IMAGE_WRITER_ROW_PAD_EN
                    if (row_end && (PAD_LEN != 0)) enter_pad = 1'b1;
                    else
`endif
                    if (row_end && last_row) finish = 1'b1;
                    else go_next = 1'b1;
                end
            end
`ifdef IMAGE_WRITER_ROW_PAD_EN
            S_PAD: begin
                if (accept && pad_last) begin
                    if (row == ROW_W'(HEIGHT)) finish = 1'b1;
                    else go_next = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        if (go_next) begin
            pop = !fifo_empty;
        end
        if (frame_start) begin
            pop = 1'b0;
        end
    end

    // Serializer, output byte register and frame position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            hold        <= '0;
            byte_idx    <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            pixel_count <= '0;
            col         <= '0;
            row         <= '0;
`ifdef IMAGE_WRITER_ROW_PAD_EN
            pad_cnt     <= '0;
`endif
        end else if (frame_start) begin
            state       <= S_IDLE;
            byte_idx    <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            pixel_count <= '0;
            col         <= '0;
            row         <= '0;
`ifdef IMAGE_WRITER_ROW_PAD_EN
            pad_cnt     <= '0;
`endif
        end else begin
            frame_done <= finish;
            if (H_sync && fifo_full) begin
                overflow <= 1'b1;
            end
            if (frame_done) begin
                pixel_count <= '0;
            end
            if (pair_done) begin
                pixel_count <= pixel_count + PC_W'(2);
                if (row_end) begin
                    col <= '0;
                    row <= finish ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col_next;
                end
            end
`ifdef IMAGE_WRITER_ROW_PAD_EN
            if ((state == S_PAD) && finish) begin
                row <= '0;
            end
`endif
            if (pop) begin
                hold       <= fifo_dout;
                byte_idx   <= BYTE_B0;
                byte_data  <= pick_byte(fifo_dout, BYTE_B0);
                byte_valid <= 1'b1;
                state      <= S_BYTES;
            end else if ((state == S_BYTES) && accept && (byte_idx != BYTE_R1)) begin
                byte_idx  <= byte_idx + 3'd1;
                byte_data <= pick_byte(hold, byte_idx + 3'd1);
`ifdef IMAGE_WRITER_ROW_PAD_EN
            end else if (enter_pad) begin
                state     <= S_PAD;
                pad_cnt   <= '0;
                byte_data <= '0;
            end else if ((state == S_PAD) && accept && !pad_last) begin
                pad_cnt <= pad_cnt + 2'd1;
`endif
            end else if (go_next || finish) begin
                state      <= S_IDLE;
                byte_valid <= 1'b0;
                byte_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_image_byte_writer.sv
// Directed bench for image_byte_writer with WIDTH=6, HEIGHT=2, FIFO_DEPTH=4.
module tb_image_byte_writer;

    localparam int W     = 6;
    localparam int H     = 2;
    localparam int DEPTH = 4;
`ifdef IMAGE_WRITER_ROW_PAD_EN
    localparam int PAD_BYTES = 2;
`else
    localparam int PAD_BYTES = 0;
`endif
    localparam int ROW_BYTES   = W * 3 + PAD_BYTES;
    localparam int FRAME_BYTES = ROW_BYTES * H;

    logic       clk;
    logic       rst;
    logic       v_sync;
    logic       h_sync;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_done;
    logic       overflow;
    logic [$clog2(W*H+1)-1:0] pixel_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         pc_q[$];
    int         fd_count;
    int         fd_at;
    int         last_at;
    int         pc_at_fd;

    image_byte_writer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .V_sync      (v_sync),
        .H_sync      (h_sync),
        .red_0       (r0),
        .green_0     (g0),
        .blue_0      (b0),
        .red_1       (r1),
        .green_1     (g1),
        .blue_1      (b1),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .pixel_count (pixel_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic [7:0] base);
        r0 = base + 8'd1; g0 = base + 8'd2; b0 = base + 8'd3;
        r1 = base + 8'd4; g1 = base + 8'd5; b1 = base + 8'd6;
    endtask

    // expected BMP bytes of a pair built by set_pair(base)
    task automatic expect_pair(input logic [7:0] base);
        exp_q.push_back(base + 8'd3); exp_q.push_back(base + 8'd2); exp_q.push_back(base + 8'd1);
        exp_q.push_back(base + 8'd6); exp_q.push_back(base + 8'd5); exp_q.push_back(base + 8'd4);
    endtask

    task automatic start_frame();
        v_sync = 1'b1;
        tick();
        v_sync = 1'b0;
        tick();
    endtask

    // accept bytes with ready=1, noting pixel_count and frame_done timing
    task automatic collect(input int want, input int budget);
        int  cyc;
        logic took;
        got_q.delete(); pc_q.delete();
        fd_count = 0; fd_at = -1; last_at = -1; pc_at_fd = -1;
        byte_ready = 1'b1;
        cyc = 0;
        while (got_q.size() < want && cyc < budget) begin
            took = byte_valid;
            if (took) begin
                got_q.push_back(byte_data);
                last_at = cyc;
            end
            tick();
            cyc++;
            if (took) pc_q.push_back(int'(pixel_count));
            if (frame_done) begin
                fd_count++; fd_at = cyc; pc_at_fd = int'(pixel_count);
            end
        end
        if (got_q.size() < want) begin
            checks++; errors++;
            $display("[TB] FAIL collect_timeout: got %0d bytes, required %0d", got_q.size(), want);
        end
    endtask

    task automatic test_reset();
        checks++; if (byte_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %0h required 0", byte_data); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b required 0", byte_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b required 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b required 0", overflow); end
        checks++; if (pixel_count !== 0) begin errors++; $display("[TB] FAIL reset_pc: got %0d required 0", pixel_count); end
    endtask

    task automatic test_byte_order();
        logic [7:0] exp_bo [12];
        exp_bo = '{8'h03, 8'h02, 8'h01, 8'h06, 8'h05, 8'h04,
                   8'h13, 8'h12, 8'h11, 8'h16, 8'h15, 8'h14};
        byte_ready = 1'b1;
        set_pair(8'h00); h_sync = 1'b1;
        tick();
        set_pair(8'h10);
        tick();
        h_sync = 1'b0;
        checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h03) begin
            errors++; $display("[TB] FAIL latency: got valid=%0b data=%0h required valid=1 data=03", byte_valid, byte_data);
        end
        collect(12, 60);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_bo[i]) begin
                errors++;
                $display("[TB] FAIL order_byte%0d: got %0h required %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_bo[i]);
            end
        end
        checks++; if (pc_q.size() < 12 || pc_q[0] != 0) begin errors++; $display("[TB] FAIL pc_first: got %0d required 0", (pc_q.size() > 0) ? pc_q[0] : -1); end
        checks++; if (pc_q.size() < 12 || pc_q[5] != 2) begin errors++; $display("[TB] FAIL pc_pair1: got %0d required 2", (pc_q.size() > 5) ? pc_q[5] : -1); end
        checks++; if (pc_q.size() < 12 || pc_q[11] != 4) begin errors++; $display("[TB] FAIL pc_pair2: got %0d required 4", (pc_q.size() > 11) ? pc_q[11] : -1); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL order_idle: got valid=%0b required 0", byte_valid); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int stall = 0;
        got_q.delete(); exp_q.delete();
        expect_pair(8'h20);
        for (int p = 0; p < PAD_BYTES; p++) exp_q.push_back(8'h00);
        byte_ready = 1'b1;
        set_pair(8'h20); h_sync = 1'b1;
        tick();
        h_sync = 1'b0;
        for (int cyc = 0; cyc < 60 && n < exp_q.size(); cyc++) begin
            if (byte_valid && n == 2 && stall < 2) begin
                byte_ready = 1'b0;
                stall++;
                checks++;
                if (byte_data !== 8'h21) begin
                    errors++; $display("[TB] FAIL stall_data%0d: got %0h required 21", stall, byte_data);
                end
            end else begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    got_q.push_back(byte_data);
                    n++;
                end
            end
            tick();
        end
        byte_ready = 1'b1;
        checks++; if (stall != 2) begin errors++; $display("[TB] FAIL stall_seen: got %0d stall cycles required 2", stall); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL bp_byte%0d: got %0h required %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_extra: got valid=%0b required 0", byte_valid); end
        checks++; if (pixel_count !== 6) begin errors++; $display("[TB] FAIL bp_pc: got %0d required 6", pixel_count); end
    endtask

    task automatic test_frame_restart();
        set_pair(8'hA0); h_sync = 1'b1;
        tick();
        h_sync = 1'b0;
        collect(3, 20);
        byte_ready = 1'b0;
        start_frame();
        checks++; if (pixel_count !== 0) begin errors++; $display("[TB] FAIL restart_pc: got %0d required 0", pixel_count); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_valid: got %0b required 0", byte_valid); end
    endtask

    task automatic test_full_frame();
        exp_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int p = 0; p < W / 2; p++) expect_pair(8'h30 + 8'(8'h10 * (r * 3 + p)));
            for (int z = 0; z < PAD_BYTES; z++) exp_q.push_back(8'h00);
        end
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    set_pair(8'h30 + 8'(8'h10 * k)); h_sync = 1'b1;
                    tick();
                    h_sync = 1'b0;
                    repeat (5) tick();
                end
            end
            collect(FRAME_BYTES, 400);
        join
        checks++; if (got_q.size() != FRAME_BYTES) begin errors++; $display("[TB] FAIL frame_len: got %0d required %0d", got_q.size(), FRAME_BYTES); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL frame_byte%0d: got %0h required %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (fd_count != 1) begin errors++; $display("[TB] FAIL done_count: got %0d required 1", fd_count); end
        checks++; if (fd_at != last_at + 1) begin errors++; $display("[TB] FAIL done_timing: got cycle %0d required %0d", fd_at, last_at + 1); end
        checks++; if (pc_at_fd != W * H) begin errors++; $display("[TB] FAIL done_pc: got %0d required %0d", pc_at_fd, W * H); end
        tick();
        checks++; if (pixel_count !== 0) begin errors++; $display("[TB] FAIL pc_cleared: got %0d required 0", pixel_count); end
    endtask

    task automatic test_overflow();
        byte_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_pair(8'h40 + 8'(8 * i)); h_sync = 1'b1;
            tick();
        end
        h_sync = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %0b required 1", overflow); end
        checks++; if (dut.u_fifo.full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full: got %0b required 1", dut.u_fifo.full); end
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'h43) begin
            errors++; $display("[TB] FAIL ovf_hold: got valid=%0b data=%0h required valid=1 data=43", byte_valid, byte_data);
        end
        start_frame();
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %0b required 0", overflow); end
        checks++; if (dut.u_fifo.empty !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flush: got empty=%0b required 1", dut.u_fifo.empty); end
        repeat (3) tick();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_valid: got %0b required 0", byte_valid); end
    endtask

    task automatic test_async_reset();
        byte_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_pair(8'h80 + 8'(8 * i)); h_sync = 1'b1;
            tick();
        end
        h_sync = 1'b0;
        repeat (4) tick();
        checks++; if (pixel_count !== 2) begin errors++; $display("[TB] FAIL pre_rst_pc: got %0d required 2", pixel_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_ovf: got %0b required 1", overflow); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid: got %0b required 0", byte_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL arst_ovf: got %0b required 0", overflow); end
        checks++; if (pixel_count !== 0) begin errors++; $display("[TB] FAIL arst_pc: got %0d required 0", pixel_count); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_valid: got %0b required 0", byte_valid); end
        checks++; if (dut.u_fifo.empty !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_empty: got %0b required 1", dut.u_fifo.empty); end
    endtask

    initial begin
        rst = 1'b1; v_sync = 1'b0; h_sync = 1'b0; byte_ready = 1'b0;
        set_pair(8'h00);
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        start_frame();
        test_byte_order();
        test_backpressure();
        test_frame_restart();
        test_full_frame();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_byte_writer.md
Name: image_byte_writer

Overview:
- Downstream sink for the image-processing read/operate stage.
- Consumes that stage's two-pixel-per-clock RGB stream, qualified by H_sync, with frames delimited by V_sync.
- Buffers pixel pairs in a small FIFO and serialises them into a BMP-ordered byte stream (B,G,R per pixel) over a valid/ready handshake, toward the file-dump or DMA logic.
- Tracks pixel position and flags frame completion and overflow.

Parameters:
- WIDTH, 768, pixels per row; must be even.
- HEIGHT, 512, rows per frame.
- DATA_WIDTH, 8, bits per colour component.
- FIFO_DEPTH, 16, pixel-pair entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, active-high, asynchronous.
- V_sync  in  1  high during upstream vertical start-up window.
- H_sync  in  1  pixel-pair valid (upstream data phase).
- red_0, green_0, blue_0  in  DATA_WIDTH each  even pixel.
- red_1, green_1, blue_1  in  DATA_WIDTH each  odd pixel.
- byte_data  out  DATA_WIDTH  current output byte.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  consumer accepts byte when valid&&ready.
- frame_done  out  1  one-cycle pulse after the last byte of the frame is accepted.
- overflow  out  1  sticky; a pair was dropped because the FIFO was full.
- pixel_count  out  $clog2(WIDTH*HEIGHT+1)  pixels fully emitted this frame.

Behaviour:
- Clock, reset and outputs
  - One clock domain: clk. Reset rst is asynchronous and active-high.
  - Reset state: FIFO empty; byte_data=0, byte_valid=0, frame_done=0, overflow=0, pixel_count=0; serializer in S_IDLE.
- Frame start
  - Registered rising edge of V_sync (V_sync=1, previous=0) starts a new frame.
  - On that edge: flush FIFO, clear overflow, pixel_count, col and row, and force the serializer to S_IDLE.
  - byte_valid may drop without acceptance in this case (abort is permitted).
- Push
  - When H_sync=1 and FIFO not full (registered full flag), write {r0,g0,b0,r1,g1,b1} at the end of the cycle.
  - If full, the pair is dropped and overflow is set.
  - Push while full is dropped even if a pop occurs in the same cycle.
- Serializer FSM
  - S_IDLE: if FIFO not empty, pop the head into the holding register, set byte_idx=0 and go to S_BYTES.
  - S_BYTES: emit bytes in the order b0,g0,r0,b1,g1,r1, indexed by byte_idx 0..5. byte_idx advances only on valid&&ready.
  - Completing byte_idx=5:
    - pixel_count += 2 and col += 2.
    - If col reaches WIDTH: col=0, row+1, then go to S_PAD (feature enabled and pad≠0) or to the next pair.
    - Otherwise pop the next pair directly if available (back-to-back, no bubble), else go to S_IDLE.
  - Last byte of pixel WIDTH*HEIGHT-1 accepted (after padding, if any): frame_done pulses the next cycle, counters reset to 0, and the FSM returns to S_IDLE. Further pairs before the next V_sync edge start a new count.
- Handshake and latency
  - byte_data and byte_valid are registered and held stable while valid && !ready.
  - Latency: pair pushed in cycle N with FIFO empty and S_IDLE → byte_valid=1 with b0 in cycle N+2.
- Throughput
  - 1 byte/clk versus 6 bytes/clk input.
  - The FIFO absorbs only bursts; sustained upstream rate above 1/6 overflows by design. Overflow is the reported error.
- Simultaneous events
  - Push and pop in the same cycle with the FIFO neither full nor empty: both occur and occupancy is unchanged.
  - Reset mid-frame: immediate return to the reset state.

Optional Feature:
- Macro: IMAGE_WRITER_ROW_PAD_EN.
- Defined:
  - After each row's last pixel byte, emit PAD=(4-(WIDTH*3)%4)%4 zero bytes in S_PAD (each needs valid&&ready), so every row is a multiple of 4 bytes (BMP row alignment).
  - frame_done follows the last row's padding.
- Undefined: no S_PAD state, no padding bytes; the row end goes directly to the next pair.

Decomposition:
- Package img_pkg holds:
  - Serializer state enum: S_IDLE, S_BYTES, S_PAD.
  - Byte-order localparams BYTE_B0..BYTE_R1 = 0..5.
  - Pad-length function row_pad_bytes(width).
- Sub-module pair_fifo: synchronous FIFO, parameters DEPTH and WIDTH=6*DATA_WIDTH, with push/pop/full/empty and registered flags.
- Counters and FSM stay in image_byte_writer.

Test Plan:
- Reset:
  - Stimulus: rst=1 asynchronously mid-burst.
  - Required: byte_valid=0, overflow=0, pixel_count=0 the same cycle; FIFO empty after release.
- Byte order:
  - Stimulus: WIDTH=4, HEIGHT=1, ready=1; pairs {r0=01,g0=02,b0=03,r1=04,g1=05,b1=06}, then {11..16}.
  - Required: bytes 03,02,01,06,05,04,13,12,11,16,15,14; frame_done one cycle after the last byte; pixel_count goes 0→2→4.
- Backpressure:
  - Stimulus: byte_ready toggled 1,0,0,1 during byte_idx=2.
  - Required: byte_data stays at r0 and byte_valid stays 1 until accepted; no byte is lost or duplicated.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, ready=0, H_sync high for 6 cycles.
  - Required: 4 pairs stored, overflow=1.
  - Then V_sync 0→1: overflow=0, FIFO empty, byte_valid=0.
- Padding (IMAGE_WRITER_ROW_PAD_EN, WIDTH=6, HEIGHT=2):
  - Required: each row emits 18 pixel bytes + 2 zero bytes, 40 bytes total; frame_done after byte 40.
  - Without the macro: 36 bytes.
- Frame restart:
  - Stimulus: V_sync rising edge after 3 bytes of a frame.
  - Required: counters 0; next pushed pair emits its b0 first; frame_done fires only after the full WIDTH*HEIGHT pixels of the new frame.
